usb_fifo_rd_ctrl: RTL and testbench
===================================

# usb_fifo_rd_ctrl

Read-side controller for the USB dual-clock FIFO, running entirely in the read clock domain. It sits directly downstream of the dual-port FIFO memory and drives that memory's read address and read enable. It synchronises the Gray-coded write pointer from the write domain and exports its own Gray read pointer back. It hides the memory's one-cycle registered-read latency behind a 2-entry output buffer and presents a valid/ready stream to the consumer.

## Interface
Parameters:
- FIFO_WIDTH, 8, data word width; matches the memory.
- FIFO_DEPTH, 64, number of entries; equals 2^ADDR_WIDTH.
- ADDR_WIDTH, 6, memory address width; pointers are ADDR_WIDTH+1 bits.

Ports:
- rdClk  in  1  read-domain clock; also clocks the memory read port.
- rdRst_n  in  1  reset, asynchronous, active-low.
- wrPtrGray  in  ADDR_WIDTH+1  write pointer, Gray code, from the wrClk domain.
- rdPtrGray  out  ADDR_WIDTH+1  registered read pointer, Gray code, to the write domain.
- addrOut  out  ADDR_WIDTH  memory read address; equals rdPtr[ADDR_WIDTH-1:0].
- readEn  out  1  memory read issue strobe (combinational).
- memDataIn  in  FIFO_WIDTH  memory registered read data.
- dataOut  out  FIFO_WIDTH  head word presented to the consumer.
- dataValid  out  1  dataOut holds a valid word.
- dataReady  in  1  consumer accepts dataOut this cycle.
- numElements  out  ADDR_WIDTH+1  words held in the memory plus words held locally.
- fifoEmpty  out  1  numElements == 0.
- fifoFlush  in  1  flush request; present only under USB_FIFO_RD_FLUSH_EN.

## Operation
- Synchronisation: 2-flop synchroniser on wrPtrGray. The second stage is converted Gray→binary to give wrBin.
- memCount = wrBin − rdPtr, computed modulo 2^(ADDR_WIDTH+1).
- Local occupancy: occ = outValid + skidValid + pend, range 0..2.
- pend is set on the cycle after an issue; it marks that memDataIn carries the issued word.
- take = dataValid && dataReady.
- Issue rule: readEn = (memCount != 0) && (occ − take < 2).
  - On issue, rdPtr increments (wraps at 2^(ADDR_WIDTH+1)).
  - rdPtrGray is registered from the new rdPtr.
- Landing (pend = 1), memDataIn routing:
  - Goes to the out register if it is empty after take.
  - Otherwise goes to the skid register.
- Shifting: when out is taken and skid is valid, skid moves to out in the same cycle. A landing word then goes to skid. Ordering is strictly FIFO.
- Outputs: dataOut = out register; dataValid = outValid.
- numElements = memCount + occ.
- The memory reads unconditionally every rdClk edge. addrOut is meaningful only on the cycle readEn is high.
- Reset values: rdPtr = 0, rdPtrGray = 0, sync stages = 0, outValid = skidValid = pend = 0, dataOut = 0, dataValid = 0, numElements = 0, fifoEmpty = 1.
- Reset mid-operation discards all local words and the in-flight read immediately (asynchronous).

## Timing
- wrPtrGray stable before rdClk edge E0:
  - memCount is nonzero after E1.
  - readEn is high during E1–E2; the memory captures the word at E2.
  - pend is high during E2–E3.
  - dataValid rises after E3 (3-edge latency).
- Steady state with dataReady held high: one word per cycle, with no bubbles.
- Consumer stalls: at most 2 words are held locally. No word is lost, and issue resumes the cycle after a take.
- Empty: readEn stays low. dataValid falls after the last take.
- Pointer wrap at the 2^(ADDR_WIDTH+1) boundary is transparent to memCount.
- Simultaneous take, landing and issue in one cycle is legal and occ is unchanged.
- rdPtrGray updates one cycle after the issue edge; it changes by exactly one bit per update.

## Configuration
- USB_FIFO_RD_FLUSH_EN defined: the fifoFlush port exists. When sampled high:
  - rdPtr is set to wrBin.
  - outValid, skidValid and pend are cleared.
  - readEn is forced low that cycle.
  - numElements = 0 and dataValid = 0 after the edge.
- Undefined: the port is absent and no flush logic is present.

## Test plan
- Reset, then 4 words written with wrPtrGray stepping 0→1→3→2→6 and dataReady = 1 → words delivered in order; dataValid first rises 3 edges after the first pointer change; fifoEmpty = 1 at the end.
- 64 words written, then dataReady = 1 → 64 consecutive dataValid cycles; numElements steps 64→0; readEn never issues past wrBin.
- dataReady toggling 1/0 every cycle on a 10-word stream → no loss or duplication; occ never exceeds 2.
- 200 words written and read continuously (pointer wraps past 127) → data integrity holds; rdPtrGray changes a single bit per update.
- dataReady = 0 with 10 words written → exactly 2 reads issued; numElements = 10; readEn low until a take.
- Flush (macro defined) with 5 words buffered and 1 in flight → numElements = 0 and dataValid = 0 next cycle; the next written word is delivered correctly.

Source files
------------

// File: rtl/usb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_fifo_rd_ctrl
// Description : Read-side controller of the USB dual-clock FIFO (rdClk domain).
//               Synchronises the Gray write pointer, drives the memory read
//               address/enable, and hides the memory's one-cycle registered
//               read behind a 2-entry out/skid buffer feeding a valid/ready
//               consumer stream.
// Ports       : rdClk/rdRst_n   - read clock, async active-low reset
//               wrPtrGray       - Gray write pointer from the wrClk domain
//               rdPtrGray       - registered Gray read pointer to wrClk domain
//               addrOut/readEn  - memory read address and issue strobe
//               memDataIn       - memory registered read data
//               dataOut/dataValid/dataReady - consumer stream
//               numElements/fifoEmpty       - occupancy status
//               fifoFlush       - flush request (USB_FIFO_RD_FLUSH_EN only)
// Options     : `define USB_FIFO_RD_FLUSH_EN to add the fifoFlush port/logic.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_fifo_rd_ctrl #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  rdClk,
  input  logic                  rdRst_n,
  input  logic [ADDR_WIDTH:0]   wrPtrGray,
  output logic [ADDR_WIDTH:0]   rdPtrGray,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  readEn,
  input  logic [FIFO_WIDTH-1:0] memDataIn,
  output logic [FIFO_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic [ADDR_WIDTH:0]   numElements,
  output logic                  fifoEmpty
`ifdef USB_FIFO_RD_FLUSH_EN
  ,
  input  logic                  fifoFlush
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  generate
    if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
      $error("FIFO_DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  // Registers
  logic [PTR_W-1:0]      sync1_q, sync2_q;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]      rdPtrGray_q;
  logic [FIFO_WIDTH-1:0] out_q, out_d;
  logic [FIFO_WIDTH-1:0] skid_q, skid_d;
  logic                  outValid_q, outValid_d;
  logic                  skidValid_q, skidValid_d;
  logic                  pend_q, pend_d;

  // Combinational
  logic [PTR_W-1:0]      w_wrBin;
  logic [PTR_W-1:0]      w_memCount;
  logic [1:0]            w_occ;
  logic [1:0]            w_occAfter;
  logic                  w_take;
  logic                  w_issue;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_wrBin    = gray2bin(sync2_q);
  // Modulo arithmetic keeps the count correct across pointer wrap.
  assign w_memCount = w_wrBin - rdPtr_q;
  assign w_occ      = {1'b0, outValid_q} + {1'b0, skidValid_q} + {1'b0, pend_q};
  assign w_take     = outValid_q & dataReady;
  // take implies outValid, so this never underflows.
  assign w_occAfter = w_occ - {1'b0, w_take};
  assign w_issue    = (w_memCount != '0) && (w_occAfter < 2'd2);

`ifdef USB_FIFO_RD_FLUSH_EN
  assign readEn = w_issue & ~fifoFlush;
`else
  assign readEn = w_issue;
`endif

  assign addrOut     = rdPtr_q[ADDR_WIDTH-1:0];
  assign rdPtrGray   = rdPtrGray_q;
  assign dataOut     = out_q;
  assign dataValid   = outValid_q;
  assign numElements = w_memCount + {{(PTR_W-2){1'b0}}, w_occ};
  assign fifoEmpty   = (numElements == '0);

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    outValid_d  = outValid_q;
    skidValid_d = skidValid_q;
    pend_d      = readEn;
    rdPtr_d     = rdPtr_q + {{(PTR_W-1){1'b0}}, readEn};

    // Consumer take: the skid word (older than any landing word) moves up.
    if (w_take) begin
      if (skidValid_q) begin
        out_d       = skid_q;
        skidValid_d = 1'b0;
      end else begin
        outValid_d  = 1'b0;
      end
    end

    // Landing word fills out if free after the take, else the skid slot.
    // The issue rule guarantees at most two local words, so skid is free here.
    if (pend_q) begin
      if (!outValid_d) begin
        out_d       = memDataIn;
        outValid_d  = 1'b1;
      end else begin
        skid_d      = memDataIn;
        skidValid_d = 1'b1;
      end
    end

`ifdef USB_FIFO_RD_FLUSH_EN
    if (fifoFlush) begin
      rdPtr_d     = w_wrBin;
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
      pend_d      = 1'b0;
    end
`endif
  end

  always_ff @(posedge rdClk or negedge rdRst_n) begin
    if (!rdRst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      rdPtr_q     <= '0;
      rdPtrGray_q <= '0;
      out_q       <= '0;
      skid_q      <= '0;
      outValid_q  <= 1'b0;
      skidValid_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      sync1_q     <= wrPtrGray;
      sync2_q     <= sync1_q;
      rdPtr_q     <= rdPtr_d;
      rdPtrGray_q <= rdPtr_d ^ (rdPtr_d >> 1);
      out_q       <= out_d;
      skid_q      <= skid_d;
      outValid_q  <= outValid_d;
      skidValid_q <= skidValid_d;
      pend_q      <= pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_fifo_rd_ctrl
// Description : Scoreboard bench for usb_fifo_rd_ctrl. A behavioural memory
//               and write-side pointer model feed the DUT; written words are
//               queued and a monitor pops/compares each accepted word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_fifo_rd_ctrl;

  localparam int W  = 8;
  localparam int AW = 6;

  logic          clk;
  logic          rst_n;
  logic [AW:0]   wrPtrGray;
  logic [AW:0]   rdPtrGray;
  logic [AW-1:0] addrOut;
  logic          readEn;
  logic [W-1:0]  memDataIn;
  logic [W-1:0]  dataOut;
  logic          dataValid;
  logic          dataReady;
  logic [AW:0]   numElements;
  logic          fifoEmpty;
`ifdef USB_FIFO_RD_FLUSH_EN
  logic          fifoFlush;
`endif

  usb_fifo_rd_ctrl #(.FIFO_WIDTH(W), .FIFO_DEPTH(64), .ADDR_WIDTH(AW)) dut (
    .rdClk       (clk),
    .rdRst_n     (rst_n),
    .wrPtrGray   (wrPtrGray),
    .rdPtrGray   (rdPtrGray),
    .addrOut     (addrOut),
    .readEn      (readEn),
    .memDataIn   (memDataIn),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .dataReady   (dataReady),
    .numElements (numElements),
    .fifoEmpty   (fifoEmpty)
`ifdef USB_FIFO_RD_FLUSH_EN
    ,
    .fifoFlush   (fifoFlush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read every edge.
  logic [W-1:0] mem [0:63];
  always @(posedge clk) memDataIn <= mem[addrOut];

  int          tests = 0;
  int          failed = 0;
  int          issued = 0;
  int          taken = 0;
  int          written = 0;
  logic [AW:0] wrBin = '0;
  logic [W-1:0] sb[$];
  logic [W-1:0] expWord;
  logic [AW:0] prevGray = '0;
  bit          flushing = 1'b0;

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    int guard;
    logic [AW:0] used;
    guard = 0;
    used = wrBin - g2b(rdPtrGray);
    while (used >= 7'd64 && guard < 1000) begin
      tick();
      guard++;
      used = wrBin - g2b(rdPtrGray);
    end
    if (guard >= 1000) check("write_full_timeout", guard, 0);
    mem[wrBin[AW-1:0]] = d;
    wrBin = wrBin + 7'd1;
    wrPtrGray = wrBin ^ (wrBin >> 1);
    sb.push_back(d);
    written++;
    tick();
  endtask

  task automatic drain();
    int g;
    g = 0;
    dataReady = 1'b1;
    while (!(fifoEmpty && !dataValid && sb.size() == 0) && g < 500) begin
      tick();
      g++;
    end
    check("drain_done", int'(g < 500), 1);
    check("drain_empty", int'(fifoEmpty), 1);
  endtask

  // Monitor: scoreboard pop, occupancy bound, issue bound, Gray step.
  always @(negedge clk) begin
    if (rst_n) begin
      if (readEn) begin
        issued++;
        if (g2b(rdPtrGray) == wrBin) check("issue_past_wr", int'(g2b(rdPtrGray)), int'(wrBin) - 1);
      end
      if (dataValid && dataReady) begin
        taken++;
        if (sb.size() == 0) begin
          check("sb_underflow", int'(dataOut), -1);
        end else begin
          expWord = sb.pop_front();
          check("data", int'(dataOut), int'(expWord));
        end
      end
      if (issued - taken > 2) check("local_occ", issued - taken, 2);
      if (rdPtrGray !== prevGray) begin
        if (!flushing) check("gray_1bit", $countones(rdPtrGray ^ prevGray), 1);
        prevGray = rdPtrGray;
      end
    end
  end

  int base;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_n = 1'b0;
    wrPtrGray = '0;
    dataReady = 1'b0;
`ifdef USB_FIFO_RD_FLUSH_EN
    fifoFlush = 1'b0;
`endif
    repeat (3) tick();
    check("rst_dataValid", int'(dataValid), 0);
    check("rst_numElements", int'(numElements), 0);
    check("rst_fifoEmpty", int'(fifoEmpty), 1);
    check("rst_rdPtrGray", int'(rdPtrGray), 0);
    check("rst_readEn", int'(readEn), 0);
    check("rst_dataOut", int'(dataOut), 0);
    rst_n = 1'b1;
    tick();

    // Test 1: four words, 3-edge first-word latency.
    dataReady = 1'b1;
    write_word(8'h11);           // returns just after E0
    tick();                      // E1
    tick();                      // E2
    check("lat_dv_E2", int'(dataValid), 0);
    tick();                      // E3
    check("lat_dv_E3", int'(dataValid), 1);
    write_word(8'h22);
    write_word(8'h33);
    write_word(8'h44);
    drain();

    // Test 2: 64 words stalled, then 64 back-to-back accepts.
    dataReady = 1'b0;
    for (int i = 0; i < 64; i++) write_word(W'(i));
    repeat (10) tick();
    check("full_numElements", int'(numElements), 64);
    dataReady = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("stream_valid", int'(dataValid), 1);
      check("stream_count", int'(numElements), 64 - i);
      tick();
    end
    check("stream_end_valid", int'(dataValid), 0);
    check("stream_end_count", int'(numElements), 0);
    drain();

    // Test 3: toggling ready over a 10-word stream.
    dataReady = 1'b0;
    for (int i = 0; i < 10; i++) write_word(8'hC0 + W'(i));
    for (int i = 0; i < 40; i++) begin
      dataReady = ~dataReady;
      tick();
    end
    drain();

    // Test 4: 200 words continuous, pointer wraps past 127.
    dataReady = 1'b1;
    for (int i = 0; i < 200; i++) write_word(W'(i * 3 + 7));
    drain();

    // Test 5: consumer stalled, only two reads may issue.
    dataReady = 1'b0;
    base = issued;
    for (int i = 0; i < 10; i++) write_word(8'hE0 + W'(i));
    repeat (10) tick();
    check("stall_issues", issued - base, 2);
    check("stall_numElements", int'(numElements), 10);
    check("stall_readEn", int'(readEn), 0);
    check("stall_dataOut", int'(dataOut), 8'hE0);
    drain();

`ifdef USB_FIFO_RD_FLUSH_EN
    // Test 6: flush with words buffered and one read in flight.
    dataReady = 1'b0;
    for (int i = 0; i < 5; i++) write_word(8'h90 + W'(i));
    repeat (10) tick();
    dataReady = 1'b1;
    tick();                      // one take, one new issue in flight
    dataReady = 1'b0;
    fifoFlush = 1'b1;
    flushing = 1'b1;
    check("flush_readEn_low", int'(readEn), 0);
    tick();
    fifoFlush = 1'b0;
    check("flush_numElements", int'(numElements), 0);
    check("flush_dataValid", int'(dataValid), 0);
    sb.delete();
    taken = issued;
    tick();
    flushing = 1'b0;
    dataReady = 1'b1;
    write_word(8'h5A);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
